mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store controller between the datapath MEM stage and the 1024x32 word data RAM, directly upstream of the RAM.
- Accepts byte-addressed word/byte requests over a req/ack handshake.
- Performs read-modify-write for sub-word stores and extracts/extends sub-word loads.
- Drives the RAM's we/addr/din and consumes its registered Dout. The RAM updates on negedge clk, so a read address driven from a posedge is readable at the next posedge.

Parameters:
- ADDR_W, 10, word-address width of the RAM; byte address is ADDR_W+2 bits.

Ports:
- clk  in  1  system clock; all block state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe, sampled in IDLE only.
- wr  in  1  1 = store, 0 = load.
- size  in  2  00 word, 01 byte, 10 halfword (see Optional Feature), 11 reserved.
- sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend (sub-word only).
- addr  in  ADDR_W+2  byte address.
- wdata  in  32  store data; sub-word stores use the low bits.
- rdata  out  32  load result register.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = request rejected.
- busy  out  1  high while not IDLE.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word address = latched addr[ADDR_W+1:2].
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data.

Behaviour:
- Reset values: state IDLE; rdata, ack, err, ram_we, ram_addr, ram_din, and all latches 0.
- Request handling:
  - IDLE with req=1 latches addr, wr, size, sign_ext, wdata, then branches.
  - req is ignored while busy=1.
- Alignment: word needs addr[1:0]=0; halfword needs addr[0]=0. Lane = addr[1:0], little-endian; byte lane n = bits [8n+7:8n].
- States: IDLE, ERR, WR, RD, RCAP, RMW_RD, RMW_WR, DONE.
- Transitions:
  - Misaligned or reserved size: IDLE->ERR. ERR: ack=1, err=1, ram_we never asserted, rdata unchanged. ->IDLE.
  - Word store: IDLE->WR->DONE->IDLE.
    - WR: ram_we=1, ram_din=wdata.
    - DONE: ack=1.
    - req at cycle 0, write at cycle 1, ack at cycle 2.
  - Load: IDLE->RD->RCAP->IDLE.
    - RD: ram_we=0, address driven.
    - RCAP: rdata <= extracted/extended ram_dout; ack registered so it is high in the cycle after RCAP, alongside the new rdata.
    - req at cycle 0, ack at cycle 3.
  - Sub-word store: IDLE->RMW_RD->RMW_WR->DONE->IDLE.
    - RMW_WR: ram_we=1; ram_din = ram_dout with the selected lane(s) replaced by wdata low bits.
    - ram_dout is stable here because the RAM does not update Dout while we=1.
    - ack at cycle 3.
- Outputs:
  - ram_we is high only in WR and RMW_WR, each for exactly one cycle.
  - ram_addr is held constant for the whole operation.
  - ack and err are high only for one cycle; err=0 on all good completions.
  - rdata holds its value until the next successful load.
- Extension:
  - Byte load: sign_ext ? {24{b[7]},b} : {24'b0,b}.
  - Word load ignores sign_ext.
- Reset mid-operation:
  - State returns to IDLE at the reset edge; no ack is issued.
  - A write whose WR/RMW_WR cycle was already active still lands at that cycle's negedge.
  - Reset during RMW_RD or RD causes no RAM write.
- Back-to-back: a new req may be accepted in the cycle after ack (IDLE).

Optional Feature:
- HALFWORD_EN defined: size=10 is legal.
  - Halfword lane is addr[1] (bits [15:0] or [31:16]).
  - Load extends from bit 15; store uses the RMW path with wdata[15:0].
- HALFWORD_EN undefined: size=10 is treated as reserved -> ERR path (ack+err, no RAM access).

Test Plan:
- Reset, then word store addr 0x010 data 0xDEADBEEF -> ram_we=1 cycle 1 with ram_addr=4, ack cycle 2 err=0. Word load 0x010 -> ack cycle 3, rdata=0xDEADBEEF.
- Word 0x11223344 at 0x010, byte store wdata=0x000000A5 at 0x013 -> single ram_we pulse in RMW_WR with ram_din=0xA5223344; ack cycle 3; reload word = 0xA5223344.
- Byte load 0x013: sign_ext=1 -> rdata=0xFFFFFFA5; sign_ext=0 -> rdata=0x000000A5. Byte load 0x010 -> 0x00000044.
- Word load at 0x012, then size=11 at 0x010 -> each gives ack=err=1 at cycle 1, ram_we never high, rdata unchanged.
- Pulse req again during busy -> ignored (one ack only). Reset asserted during RMW_RD of a byte store -> no ram_we, no ack, RAM word unchanged, busy=0 after reset.
- HALFWORD_EN: halfword store 0xBEEF at 0x012 over 0x11223344 -> 0xBEEF3344; signed halfword load -> 0xFFFFBEEF. Without HALFWORD_EN the same store -> ack+err, RAM unchanged.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request-side bus of mem_access_unit: the datapath MEM stage drives the request
// fields (master modport), and the unit returns the load result and the
// completion status (slave modport).
interface mem_access_unit_if #(
  parameter int ADDR_W = 10
) ();
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, wr, size, sign_ext, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, wr, size, sign_ext, addr, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of the 1024x32 data RAM.
// Word accesses go straight to the RAM. Sub-word stores read the word, merge
// the new lane(s) and write it back. Sub-word loads pick the lane and extend it.
// Build option: define HALFWORD_EN to make size=2'b10 (halfword) legal;
// without it halfword requests take the error path.
//
// state  | meaning
// IDLE   | waiting for req, latches request fields
// ERR    | misaligned/reserved request, ack+err pulse
// WR     | word store, ram_we high
// RD     | load, RAM address being read
// RCAP   | load, ram_dout captured into rdata, ack next cycle
// RMW_RD | sub-word store, reading the old word
// RMW_WR | sub-word store, writing the merged word
// DONE   | store complete, ack pulse
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ERR    = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_RCAP   = 3'd4;
  localparam logic [2:0] S_RMW_RD = 3'd5;
  localparam logic [2:0] S_RMW_WR = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sign_ext_q, sign_ext_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              ram_we_q, ram_we_d;
  logic [31:0]       ram_din_q, ram_din_d;

  logic              legal;
  logic [7:0]        lane_byte;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  // Alignment and size legality of the incoming request.
  always_comb begin
    legal = 1'b0;
    case (bus.size)
      2'b00:   legal = (bus.addr[1:0] == 2'b00);
      2'b01:   legal = 1'b1;
`ifdef HALFWORD_EN
      2'b10:   legal = !bus.addr[0];
`endif
      default: legal = 1'b0;
    endcase
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  // ram_din_q holds the latched store data from acceptance until the merge.
  always_comb begin
    lane_byte = 8'h00;
    case (addr_q[1:0])
      2'd0:    lane_byte = ram_dout[7:0];
      2'd1:    lane_byte = ram_dout[15:8];
      2'd2:    lane_byte = ram_dout[23:16];
      default: lane_byte = ram_dout[31:24];
    endcase
    load_val = {{24{sign_ext_q & lane_byte[7]}}, lane_byte};
    merged   = ram_dout;
    if (size_q == 2'b00) begin
      load_val = ram_dout;
    end
`ifdef HALFWORD_EN
    else if (size_q == 2'b10) begin
      if (addr_q[1]) begin
        load_val      = {{16{sign_ext_q & ram_dout[31]}}, ram_dout[31:16]};
        merged[31:16] = ram_din_q[15:0];
      end else begin
        load_val      = {{16{sign_ext_q & ram_dout[15]}}, ram_dout[15:0]};
        merged[15:0]  = ram_din_q[15:0];
      end
    end
`endif
    else begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = ram_din_q[7:0];
        2'd1:    merged[15:8]  = ram_din_q[7:0];
        2'd2:    merged[23:16] = ram_din_q[7:0];
        default: merged[31:24] = ram_din_q[7:0];
      endcase
    end
  end

  // Next-state and registered-output logic; the write strobe and ack are
  // derived from the state being entered so they line up with it exactly.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    sign_ext_d = sign_ext_q;
    rdata_d    = rdata_q;
    ram_din_d  = ram_din_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_d     = bus.addr;
          size_d     = bus.size;
          sign_ext_d = bus.sign_ext;
          if (bus.wr) begin
            ram_din_d = bus.wdata;
          end
          if (!legal) begin
            state_d = S_ERR;
          end else if (bus.wr && (bus.size == 2'b00)) begin
            state_d = S_WR;
          end else if (bus.wr) begin
            state_d = S_RMW_RD;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_ERR:    state_d = S_IDLE;
      S_WR:     state_d = S_DONE;
      S_RD:     state_d = S_RCAP;
      S_RCAP: begin
        rdata_d = load_val;
        state_d = S_IDLE;
      end
      S_RMW_RD: begin
        ram_din_d = merged;
        state_d   = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    ram_we_d = (state_d == S_WR) || (state_d == S_RMW_WR);
    ack_d    = (state_d == S_ERR) || (state_d == S_DONE) || (state_q == S_RCAP);
    err_d    = (state_d == S_ERR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      sign_ext_q <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      sign_ext_q <= sign_ext_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      ram_we_q   <= ram_we_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: byte-array reference memory, ack and RAM-write
// scoreboards, directed cases followed by random traffic.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;
  logic [31:0] ram [0:1023];

  mem_access_unit_if #(.ADDR_W(10)) bus ();

  mem_access_unit #(.ADDR_W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Data RAM: updates on negedge, Dout held while writing.
  always @(negedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    else        ram_dout <= ram[ram_addr];
  end

  typedef struct { int cyc; logic err; logic [31:0] rdata; } exp_t;
  typedef struct { logic [9:0] a; logic [31:0] d; } wr_t;
  exp_t aq[$];
  wr_t  wq[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acks_seen = 0;
  logic [7:0]  ref_bytes [0:4095];
  logic [31:0] ref_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int byte_addr);
    int base;
    base = byte_addr & ~3;
    return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
  endfunction

  // Ack monitor.
  always @(negedge clk) begin
    if (!rst && bus.ack) begin
      exp_t e;
      acks_seen++;
      if (aq.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = aq.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        chk("err", {31'd0, bus.err}, {31'd0, e.err});
        chk("rdata", bus.rdata, e.rdata);
      end
    end
  end

  // RAM write monitor.
  always @(negedge clk) begin
    if (ram_we) begin
      wr_t w;
      if (wq.size() == 0) begin
        chk("unexpected_ram_we", {22'd0, ram_addr}, 32'hFFFF_FFFF);
      end else begin
        w = wq.pop_front();
        chk("ram_addr", {22'd0, ram_addr}, {22'd0, w.a});
        chk("ram_din", ram_din, w.d);
      end
    end
  end

  // Issue one request, push the reference expectations, wait for its ack.
  // hold > 1 keeps req high into busy cycles, which must be ignored.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input int a, input logic [31:0] wd, input int hold);
    int    nb, lat, target;
    logic  ok;
    longint v;
    logic [31:0] t;
    exp_t  e;
    wr_t   wr;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a[11:0]; bus.wdata = wd;
    ok = (sz == 2'b01) || (sz == 2'b00 && (a % 4) == 0);
`ifdef HALFWORD_EN
    if (sz == 2'b10 && (a % 2) == 0) ok = 1'b1;
`endif
    nb = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 1 : 2;
    e.err = 1'b0;
    if (!ok) begin
      lat = 1; e.err = 1'b1;
    end else if (w) begin
      lat = (sz == 2'b00) ? 2 : 3;
      for (int i = 0; i < nb; i++) begin
        t = wd >> (8 * i);
        ref_bytes[a + i] = t[7:0];
      end
      wr.a = 10'(a / 4);
      wr.d = ref_word(a);
      wq.push_back(wr);
    end else begin
      lat = 3;
      v = 0;
      for (int i = 0; i < nb; i++) v = v + (longint'(ref_bytes[a + i]) << (8 * i));
      if (sx && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      ref_rdata = v[31:0];
    end
    e.cyc = cyc + lat;
    e.rdata = ref_rdata;
    aq.push_back(e);
    target = acks_seen + 1;
    if (hold > lat) hold = lat;
    repeat (hold) @(negedge clk);
    bus.req = 1'b0;
    for (int k = 0; k < 12 && acks_seen < target; k++) begin
      @(negedge clk); #1;
    end
    if (acks_seen < target) chk("ack_timeout", acks_seen, target);
  endtask

  initial begin
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 4096; i++) ref_bytes[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_ack_err_busy_we", {28'd0, bus.ack, bus.err, bus.busy, ram_we}, 32'h0);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'h0);
    chk("rst_ram_din", ram_din, 32'h0);
    rst = 1'b0;

    issue(1, 2'b00, 0, 12'h010, 32'hDEADBEEF, 1);
    issue(0, 2'b00, 0, 12'h010, 32'h0, 1);
    chk("word_load", bus.rdata, 32'hDEADBEEF);
    issue(1, 2'b00, 0, 12'h010, 32'h11223344, 1);
    issue(1, 2'b01, 0, 12'h013, 32'h000000A5, 1);
    issue(0, 2'b00, 0, 12'h010, 32'h0, 1);
    chk("rmw_reload", bus.rdata, 32'hA5223344);
    issue(0, 2'b01, 1, 12'h013, 32'h0, 1);
    chk("byte_load_sext", bus.rdata, 32'hFFFFFFA5);
    issue(0, 2'b01, 0, 12'h013, 32'h0, 1);
    chk("byte_load_zext", bus.rdata, 32'h000000A5);
    issue(0, 2'b01, 1, 12'h010, 32'h0, 1);
    chk("byte_load_lane0", bus.rdata, 32'h00000044);
    issue(0, 2'b00, 0, 12'h012, 32'h0, 1);
    issue(0, 2'b11, 0, 12'h010, 32'h0, 1);
    chk("err_rdata_kept", bus.rdata, 32'h00000044);
    issue(0, 2'b00, 0, 12'h010, 32'h0, 3);
    repeat (4) @(negedge clk);

    // Reset while in RMW_RD of a byte store.
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b01; bus.sign_ext = 1'b0;
    bus.addr = 12'h011; bus.wdata = 32'h0000005A;
    @(negedge clk);
    bus.req = 1'b0;
    chk("rmw_rd_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = '0;
    chk("busy_after_rst", {31'd0, bus.busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("ram_unchanged_after_rst", ram[4], 32'hA5223344);

    issue(1, 2'b00, 0, 12'h010, 32'h11223344, 1);
    issue(1, 2'b10, 0, 12'h012, 32'h0000BEEF, 1);
    issue(0, 2'b10, 1, 12'h012, 32'h0, 1);
`ifdef HALFWORD_EN
    chk("hw_store", ram[4], 32'hBEEF3344);
    chk("hw_load_sext", bus.rdata, 32'hFFFFBEEF);
`else
    chk("hw_store_rejected", ram[4], 32'h11223344);
`endif

    for (int n = 0; n < 250; n++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 63)), $urandom, int'($urandom_range(1, 3)));
    end
    repeat (5) @(negedge clk);

    for (int i = 0; i < 16; i++) chk("final_ram", ram[i], ref_word(i * 4));
    chk("ack_queue_empty", aq.size(), 32'd0);
    chk("write_queue_empty", wq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
